// File: rtl/step_pkg.sv
// step_pkg: shared state encoding, direction polarity and step-rate limit for the step pulse generator
package step_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, ACTIVE} state_e;
  localparam logic DIR_POS = 1'b1;
  function automatic int unsigned max_steps(input int unsigned sim_period, input int unsigned pulse_width);
    return sim_period / (2 * pulse_width);
  endfunction
endpackage

// File: rtl/step_pulse_generator_if.sv
// step_pulse_generator_if: period-delta input and STEP/DIR/status outputs of the step pulse generator
interface step_pulse_generator_if #(parameter int W = 16);
  logic sync_sim_clock;
  logic enable;
  logic signed [W-1:0] delta_steps;
  logic step;
  logic dir;
  logic signed [W-1:0] motor_pos;
  logic busy;
  logic overrun;
  logic [W-1:0] dropped_steps;
  modport master(output sync_sim_clock, enable, delta_steps, input step, dir, motor_pos, busy, overrun, dropped_steps);
  modport slave(input sync_sim_clock, enable, delta_steps, output step, dir, motor_pos, busy, overrun, dropped_steps);
endinterface

// File: rtl/step_rate_accumulator.sv
// step_rate_accumulator: phase accumulator that spreads mag steps evenly over a period and counts pending steps
module step_rate_accumulator
  import step_pkg::*;
#(
  parameter int unsigned simPeriod = 500_000,
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic         clear,
  input  logic         run,
  input  logic         take,
  input  logic [W-1:0] mag,
  output logic         pending_nz,
  output logic [7:0]   pending,
  output logic [7:0]   pending_left
);
  logic [31:0] acc_q, acc_d, acc_sum;
  logic [W-1:0] mag_q, mag_d;
  logic [7:0] pending_q, pending_d;
  logic [8:0] pend_sum;
  logic ovf;
  always_comb begin
    acc_sum = acc_q + 32'(mag_q);
    ovf = run && acc_sum >= simPeriod;
    pend_sum = 9'(pending_q) + 9'(ovf) - 9'(take);
    pending_left = pend_sum[8] ? 8'hFF : pend_sum[7:0];
    // a step due this very cycle can be issued immediately, before it lands in pending
    pending_nz = pending_q != '0 || ovf;
    acc_d = clear ? '0 : load ? 32'(simPeriod / 2) : ovf ? acc_sum - 32'(simPeriod) : run ? acc_sum : acc_q;
    mag_d = clear ? '0 : load ? mag : mag_q;
    pending_d = (clear || load) ? '0 : pending_left;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q <= '0;
      mag_q <= '0;
      pending_q <= '0;
    end else begin
      acc_q <= acc_d;
      mag_q <= mag_d;
      pending_q <= pending_d;
    end
  end
  assign pending = pending_q;
endmodule

// File: rtl/step_pulse_generator.sv
// step_pulse_generator: turns per-period microstep deltas into evenly spaced STEP pulses with DIR setup
module step_pulse_generator
  import step_pkg::*;
#(
  parameter int unsigned simPeriod = 500_000,
  parameter int fixedPointBaseBits = 16,
  parameter int unsigned PULSE_WIDTH = 100,
  parameter int unsigned DIR_SETUP = 50
) (
  input logic clock,
  input logic reset,
  step_pulse_generator_if.slave bus
);
  localparam int W = fixedPointBaseBits;
  localparam int unsigned MAX_STEPS = max_steps(simPeriod, PULSE_WIDTH);
  localparam int PW_W = $clog2(PULSE_WIDTH + 1);
  localparam int DS_W = $clog2(DIR_SETUP + 2);
  state_e state_q, state_d;
  logic sim_prev_q, sim_prev_d, load_req_q, load_req_d;
  logic step_q, step_d, dir_q, dir_d, overrun_q, overrun_d;
  logic [PW_W-1:0] pulse_cnt_q, pulse_cnt_d;
  logic [DS_W-1:0] setup_cnt_q, setup_cnt_d;
  logic [W-1:0] remaining_q, remaining_d, motor_pos_q, motor_pos_d, dropped_q, dropped_d;
  logic [W-1:0] abs_v, mag, rem_left;
  logic [31:0] drop_sum;
  logic [7:0] pending, pending_left;
  logic load, issue, pending_nz, want_dir;
  step_rate_accumulator #(.simPeriod(simPeriod), .W(W)) u_acc (
    .clock,
    .reset,
    .load,
    .clear(!bus.enable),
    .run(state_q == ACTIVE && bus.enable),
    .take(issue),
    .mag,
    .pending_nz,
    .pending,
    .pending_left
  );
  always_comb begin
    sim_prev_d = bus.sync_sim_clock;
    load_req_d = bus.sync_sim_clock && !sim_prev_q;
    load = load_req_q && bus.enable;
    abs_v = bus.delta_steps[W-1] ? W'(-bus.delta_steps) : W'(bus.delta_steps);
    mag = 32'(abs_v) > MAX_STEPS ? W'(MAX_STEPS) : abs_v;
    want_dir = bus.delta_steps[W-1] ? ~DIR_POS : DIR_POS;
    issue = state_q == ACTIVE && bus.enable && !step_q && pending_nz && remaining_q != '0;
    rem_left = remaining_q - W'(issue);
    drop_sum = 32'(dropped_q) + 32'(rem_left) + 32'(pending_left);
    state_d = state_q;
    dir_d = dir_q;
    step_d = step_q;
    pulse_cnt_d = pulse_cnt_q;
    setup_cnt_d = setup_cnt_q;
    remaining_d = rem_left;
    motor_pos_d = motor_pos_q;
    overrun_d = overrun_q;
    dropped_d = dropped_q;
    if (issue) begin
      step_d = 1'b1;
      pulse_cnt_d = PW_W'(PULSE_WIDTH - 1);
      motor_pos_d = motor_pos_q + (dir_q == DIR_POS ? W'(1) : {W{1'b1}});
    end else if (step_q) begin
      step_d = pulse_cnt_q != '0;
      pulse_cnt_d = pulse_cnt_q - PW_W'(1);
    end
    // DIR flips only once any in-flight pulse has ended, then holds for DIR_SETUP cycles
    if (state_q == SETUP && !(setup_cnt_q == '0 && step_q)) begin
      dir_d = setup_cnt_q == '0 ? ~dir_q : dir_q;
      setup_cnt_d = setup_cnt_q + DS_W'(1);
      state_d = setup_cnt_q == DS_W'(DIR_SETUP) ? ACTIVE : SETUP;
    end
    if (state_q == ACTIVE && remaining_q == '0 && !step_q) state_d = IDLE;
    if (load) begin
      remaining_d = mag;
      setup_cnt_d = '0;
      overrun_d = overrun_q || rem_left != '0 || pending_left != '0;
      dropped_d = drop_sum > 32'({W{1'b1}}) ? {W{1'b1}} : W'(drop_sum);
      state_d = mag == '0 ? IDLE : want_dir == dir_q ? ACTIVE : SETUP;
    end
    if (!bus.enable) begin
      state_d = IDLE;
      remaining_d = '0;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      sim_prev_q <= 1'b0;
      load_req_q <= 1'b0;
      step_q <= 1'b0;
      dir_q <= 1'b0;
      overrun_q <= 1'b0;
      pulse_cnt_q <= '0;
      setup_cnt_q <= '0;
      remaining_q <= '0;
      motor_pos_q <= '0;
      dropped_q <= '0;
    end else begin
      state_q <= state_d;
      sim_prev_q <= sim_prev_d;
      load_req_q <= load_req_d;
      step_q <= step_d;
      dir_q <= dir_d;
      overrun_q <= overrun_d;
      pulse_cnt_q <= pulse_cnt_d;
      setup_cnt_q <= setup_cnt_d;
      remaining_q <= remaining_d;
      motor_pos_q <= motor_pos_d;
      dropped_q <= dropped_d;
    end
  end
  assign bus.step = step_q;
  assign bus.dir = dir_q;
  assign bus.motor_pos = motor_pos_q;
  assign bus.busy = state_q != IDLE || pending != '0;
  assign bus.overrun = overrun_q;
  assign bus.dropped_steps = dropped_q;
endmodule

// File: tb/tb_step_pulse_generator.sv
// tb_step_pulse_generator: scoreboard bench predicting every STEP rise time, DIR and position per loaded period
module tb_step_pulse_generator;
  localparam int P = 2000;
  localparam int PW = 10;
  localparam int DS = 5;
  localparam int W = 16;
  localparam int MAXS = P / (2 * PW);
  localparam int ALL = 1 << 20;
  typedef struct {int cyc; logic dir; int pos;} exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int pos_m = 0;
  int drop_m = 0;
  logic dir_m = 1'b0;
  logic ovr_m = 1'b0;
  int e0_last = 0;
  int t_start = 0;
  exp_t sb[$];
  logic sp = 1'b0;
  logic dp = 1'b0;
  int hi = 0;
  int dchg = -1;
  exp_t e;
  step_pulse_generator_if #(.W(W)) bus();
  step_pulse_generator #(.simPeriod(P), .fixedPointBaseBits(W), .PULSE_WIDTH(PW), .DIR_SETUP(DS)) dut (
    .clock(clk),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask
  task automatic load_period(input logic signed [15:0] d, input int limit);
    int a, mag, l;
    logic want;
    check("pos_before_load", bus.motor_pos, pos_m);
    check("overrun", bus.overrun, ovr_m);
    check("dropped", bus.dropped_steps, drop_m);
    a = d < 0 ? -int'(d) : int'(d);
    mag = a > MAXS ? MAXS : a;
    l = cyc + 2;
    bus.delta_steps = d;
    bus.sync_sim_clock = 1'b1;
    if (mag != 0) begin
      want = d >= 0;
      e0_last = l + (want != dir_m ? 1 + DS : 0);
      dir_m = want;
      for (int j = 1; j <= mag && j <= limit; j++) begin
        pos_m += want ? 1 : -1;
        sb.push_back('{e0_last + ((2 * j - 1) * P + 2 * mag - 1) / (2 * mag), want, pos_m});
      end
    end
    repeat (5) @(negedge clk);
    bus.sync_sim_clock = 1'b0;
    if (mag != 0) check("busy", bus.busy, 1);
  endtask
  task automatic period(input logic signed [15:0] d);
    int t;
    t = cyc;
    load_period(d, ALL);
    wait_until(t + P);
  endtask
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (bus.dir !== dp) begin
          check("dir_chg_step_low", bus.step, 0);
          dchg = cyc;
        end
        if (bus.step && !sp) begin
          if (sb.size() == 0) check("extra_rise", cyc, -1);
          else begin
            e = sb.pop_front();
            check("rise_cyc", cyc, e.cyc);
            check("rise_dir", bus.dir, e.dir);
            check("rise_pos", bus.motor_pos, e.pos);
          end
          if (dchg >= 0) begin
            check("dir_setup", (cyc - dchg) >= DS, 1);
            dchg = -1;
          end
          hi = 1;
        end else if (bus.step) hi++;
        else if (sp) check("pulse_width", hi, PW);
      end else hi = 0;
      sp = bus.step;
      dp = bus.dir;
    end
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bus.sync_sim_clock = 1'b0;
    bus.delta_steps = '0;
    bus.enable = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_step", bus.step, 0);
    check("rst_dir", bus.dir, 0);
    check("rst_pos", bus.motor_pos, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_overrun", bus.overrun, 0);
    check("rst_dropped", bus.dropped_steps, 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_busy", bus.busy, 0);
    period(16'sd1);
    period(16'sd100);
    period(16'sd10);
    period(-16'sd10);
    period(-16'sd32768);
    period(16'sd0);
    check("dir_after_neg", bus.dir, 0);
    t_start = cyc;
    load_period(16'sd10, 3);
    wait_until(e0_last + 505);
    bus.enable = 1'b0;
    repeat (2) @(negedge clk);
    check("busy_disabled", bus.busy, 0);
    wait_until(e0_last + 1000);
    bus.enable = 1'b1;
    wait_until(t_start + P);
    t_start = cyc;
    load_period(16'sd10, 5);
    wait_until(e0_last + 998);
    t_start = cyc;
    load_period(16'sd0, 0);
    check("dropped_early", bus.dropped_steps, 5);
    check("overrun_early", bus.overrun, 1);
    check("busy_after_drop", bus.busy, 0);
    drop_m = 5;
    ovr_m = 1'b1;
    wait_until(t_start + P);
    load_period(16'sd10, 1);
    wait_until(e0_last + 105);
    check("mid_pulse_step", bus.step, 1);
    reset = 1'b1;
    @(negedge clk);
    check("rstmid_step", bus.step, 0);
    check("rstmid_pos", bus.motor_pos, 0);
    check("rstmid_busy", bus.busy, 0);
    check("rstmid_dir", bus.dir, 0);
    check("rstmid_overrun", bus.overrun, 0);
    check("rstmid_dropped", bus.dropped_steps, 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/step_pulse_generator.md
# step_pulse_generator

Downstream stage of the motion simulator. Consumes the per-period signed microstep delta (`delta_steps`, step/16 units) and converts it into evenly spaced STEP pulses plus a DIR level for the stepper driver. Tracks issued steps in `motor_pos` so the bench can compare it with the simulator's `current_pos`. All logic runs on the system clock; the simulator's `sync_sim_clock` is treated as a data input and edge-detected.

## Interface
- `simPeriod`, 500_000: system-clock cycles per simulation period; same value as the simulator.
- `fixedPointBaseBits`, 16: width of `delta_steps` and `motor_pos`.
- `PULSE_WIDTH`, 100: STEP high time in cycles.
- `DIR_SETUP`, 50: minimum cycles between a DIR change and the next STEP rise.
- `clock` in 1: system clock.
- `reset` in 1: reset, synchronous, active-high.
- `sync_sim_clock` in 1: simulator period clock, same clock domain.
- `delta_steps` in 16, signed: steps to issue this period.
- `enable` in 1: driver enable; 0 suppresses all stepping.
- `step` out 1: STEP pulse, registered.
- `dir` out 1: 1 = positive direction, registered.
- `motor_pos` out 16, signed: running count of issued steps.
- `busy` out 1: high when the state is not IDLE or `pending` is nonzero.
- `overrun` out 1: sticky flag; set when steps are dropped.
- `dropped_steps` out 16: count of dropped steps, saturating at 16'hFFFF.

## Operation
- **Reset values:** every output is 0; state IDLE; `acc` = 0; `remaining` = 0; `pending` = 0.
- **Edge detect:** `sim_prev` registers `sync_sim_clock`. A rising edge (`prev`=0, `cur`=1) sets `load_req`. The load happens on the next edge, giving one cycle of margin for `delta_steps` to settle.
- **Load:**
  - `mag` = |`delta_steps`|, clamped to `MAX_STEPS` = `simPeriod`/(2·`PULSE_WIDTH`), which is 2500 by default. −32768 clamps to the same limit.
  - Any `remaining`+`pending` left from the previous period is added to `dropped_steps` and sets `overrun`.
  - Then `remaining` ← `mag`, `pending` ← 0, `acc` ← `simPeriod`/2.
- **Load when `mag` = 0:** go to IDLE; `dir` is held.
- **Load when the sign matches `dir` (or `mag` ≠ 0 and no change is needed):** go to ACTIVE.
- **Load with a direction change:** go to SETUP.
- **SETUP:**
  - Wait until `step` is low.
  - Then update `dir` (1 for a positive delta).
  - Count `DIR_SETUP` cycles, then go to ACTIVE.
- **ACTIVE:**
  - Each cycle: `acc_next` = `acc` + `mag`.
  - If `acc_next` ≥ `simPeriod`: `acc` ← `acc_next` − `simPeriod` and `pending`++ (8-bit, saturating).
  - When `step` is low, the pulse timer is idle, `pending` > 0 and `remaining` > 0:
    - `step` rises (registered);
    - `pending`−−, `remaining`−−;
    - `motor_pos` += `dir` ? +1 : −1, wrapping in two's complement.
  - `step` stays high for exactly `PULSE_WIDTH` cycles.
  - When `remaining` = 0 and `step` is low, go to IDLE.
- **`enable` = 0:**
  - Forces IDLE and clears `remaining`, `pending` and `acc`; these are not counted as dropped.
  - An in-flight pulse completes its full width.
  - Loads are ignored while `enable` is low.
- **Simultaneous events:**
  - A STEP rise in the same cycle as a load counts as issued, not dropped.
  - A reset in the same cycle as any event wins.
- **Width:** `acc` is 32 bits unsigned; `acc` + `mag` < `simPeriod` + `MAX_STEPS`, so it cannot overflow.

## Timing
- Count the ACTIVE entry edge as E0. Accumulation i occurs at edge Ei.
- The first STEP rise is at Ek, where k = ceil(`simPeriod`/(2·`mag`)). Later rises follow every `simPeriod`/`mag` cycles; the integer remainder is carried in `acc`.
- Pulses are centred in the period; the last pulse ends by `simPeriod`. The clamp guarantees a spacing of at least 2·`PULSE_WIDTH`.
- Load-to-ACTIVE latency:
  - 1 cycle when no direction change is needed;
  - 1 + `DIR_SETUP` cycles when `dir` changes, plus any wait for an in-flight pulse.
- Edge-to-load latency: 1 cycle after `load_req`, which is 2 cycles after `sync_sim_clock` rises.

## Structure
- Package `step_pkg` holds:
  - the state enum (IDLE, SETUP, ACTIVE);
  - `DIR_POS` = 1'b1;
  - the `MAX_STEPS` function of `simPeriod` and `PULSE_WIDTH`.
- Sub-module `step_rate_accumulator` holds `acc`, `mag` and the `pending` counter. Its inputs are `load`, `mag` and `run`; its output is `pending_nz`, with a `take` strobe to consume one pending step.

## Test plan
- `delta_steps` = +1, default parameters → one pulse of 100 cycles, rising 250_000 cycles after ACTIVE entry; `dir` = 1; `motor_pos` = 1.
- `delta_steps` = +2500 for one period → 2500 pulses spaced 200 cycles apart; `overrun` = 0; `motor_pos` = 2500.
- `delta_steps` = +10 then −10 → `dir` falls only while `step` is low; the first negative pulse is ≥ 50 cycles after `dir` changes; `motor_pos` returns to 0.
- `delta_steps` = −32768 → clamped to 2500 pulses; `dir` = 0; `motor_pos` = −2500.
- A period loaded with +10, then `enable` deasserted mid-period and re-asserted before the next load → no further pulses that period; `dropped_steps` = 0; `overrun` = 0. Separately, forcing an early `sync_sim_clock` edge with 5 steps still remaining → `dropped_steps` = 5 and `overrun` = 1.
- `reset` asserted mid-pulse → the next cycle `step` = 0, `motor_pos` = 0 and `busy` = 0, with all outputs at their reset values.
